// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: accepts one pc at a time, returns the stored word
// (or an error) LATENCY cycles later, with flush and a side load port for the program store.
module imem_fetch_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_data,
    output logic [31:0]                    rsp_addr,
    output logic                           rsp_err,
    input  logic                           flush,
    input  logic                           load_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  logic [31:0]                    load_data,
    output logic [15:0]                    fetch_cnt
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [2:0]  CNT_INIT  = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    logic [31:0] req_offset;
    logic        req_err;
    logic [31:0] req_word;
    logic        accept;
    logic        rsp_done;

    // Program store has no reset; loads are honoured in every state.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_idx] <= load_data;
        end
    end

    always_comb begin
        req_offset = req_addr - BASE_ADDR;
        req_err    = (req_addr[1:0] != 2'b00) || ({1'b0, req_offset} >= MEM_BYTES);
        req_word   = mem[req_offset[IDX_W+1:2]];

        rsp_valid  = (state_q == S_RESP);
        req_ready  = !rst && !flush &&
                     ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
        accept     = req_valid && req_ready;
        rsp_done   = rsp_valid && rsp_ready && !flush;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        fetch_cnt_d = fetch_cnt_q + {15'd0, rsp_done};

        unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The word is captured at the accept edge, so a same-edge load returns the old value.
        if (accept) begin
            rsp_data_d = req_err ? 32'h0 : req_word;
            rsp_addr_d = req_addr;
            rsp_err_d  = req_err;
            state_d    = (LATENCY == 1) ? S_RESP : S_WAIT;
            cnt_d      = CNT_INIT;
        end

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            rsp_data_q  <= 32'h0;
            rsp_addr_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            fetch_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: one LATENCY=1 instance at base 0 and one
// LATENCY=3 instance at base 0x1000 share stimulus; expected responses come from a scoreboard.
module tb_imem_fetch_responder;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    localparam logic [31:0] B_BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        load_we;
    logic [7:0]  load_idx;
    logic [31:0] load_data;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_data, a_rsp_addr;
    logic [15:0] a_fetch_cnt;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_data, b_rsp_addr;
    logic [15:0] b_fetch_cnt;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] model_mem [256];
    exp_t        sb [$];
    logic [31:0] err_addrs [4];

    always #5 clk = ~clk;

    imem_fetch_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(a_rsp_data), .rsp_addr(a_rsp_addr), .rsp_err(a_rsp_err),
        .flush(flush), .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
        .fetch_cnt(a_fetch_cnt)
    );

    imem_fetch_responder #(.DEPTH_WORDS(256), .BASE_ADDR(B_BASE), .LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(b_rsp_data), .rsp_addr(b_rsp_addr), .rsp_err(b_rsp_err),
        .flush(flush), .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
        .fetch_cnt(b_fetch_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic r, input logic f);
        req_valid = v;
        req_addr  = a;
        rsp_ready = r;
        flush     = f;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    function automatic exp_t expectFor(input logic [31:0] addr, input logic [31:0] base);
        exp_t        e;
        logic [31:0] off;
        off    = addr - base;
        e.addr = addr;
        e.err  = (addr[1:0] != 2'b00) || (off >= 32'd1024);
        e.data = e.err ? 32'h0 : model_mem[off[9:2]];
        return e;
    endfunction

    task automatic pushReq(input logic [31:0] addr, input logic [31:0] base);
        sb.push_back(expectFor(addr, base));
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic [31:0] d,
                            input logic [31:0] a, input logic e);
        exp_t x;
        checkOutput({tag, "_valid"}, {31'd0, v}, 32'd1);
        tests++;
        assert (sb.size() != 0) else begin
            failed++;
            $error("[TB] FAIL %s_sb: observed empty scoreboard, expected a pending entry", tag);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            checkOutput({tag, "_data"}, d, x.data);
            checkOutput({tag, "_addr"}, a, x.addr);
            checkOutput({tag, "_err"}, {31'd0, e}, {31'd0, x.err});
        end
    endtask

    task automatic waitRspB(input int budget);
        int n = 0;
        while (!b_rsp_valid && n < budget) begin
            cycle();
            n++;
        end
    endtask

    task automatic loadWord(input logic [7:0] idx, input logic [31:0] data);
        load_we   = 1'b1;
        load_idx  = idx;
        load_data = data;
        cycle();
        load_we        = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic doReset();
        cycle();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cycle();
        checkOutput("rst_req_ready_a", {31'd0, a_req_ready}, 32'd0);
        checkOutput("rst_req_ready_b", {31'd0, b_req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", a_rsp_data, 32'h0);
        checkOutput("rst_rsp_addr", a_rsp_addr, 32'h0);
        checkOutput("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        checkOutput("rst_cnt_a", {16'd0, a_fetch_cnt}, 32'd0);
        checkOutput("rst_cnt_b", {16'd0, b_fetch_cnt}, 32'd0);
        checkOutput("idle_req_ready", {31'd0, a_req_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        load_we   = 1'b0;
        load_idx  = 8'd0;
        load_data = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        err_addrs[0] = 32'h0000_0002;
        err_addrs[1] = 32'h0000_0400;
        err_addrs[2] = 32'hFFFF_FFFC;
        err_addrs[3] = 32'h0000_03FC;

        doReset();
        loadWord(8'd0, 32'h13);
        loadWord(8'd1, 32'h93);
        loadWord(8'd2, 32'h113);
        loadWord(8'd3, 32'h193);
        loadWord(8'd5, 32'h5555_5555);
        loadWord(8'd255, 32'hA5A5_0FF0);

        // LATENCY=1 streaming: one response per cycle in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b1, 1'b0);
            pushReq(32'(i * 4), 32'h0);
            #1 checkOutput("t1_req_ready", {31'd0, a_req_ready}, 32'd1);
            cycle();
            checkRsp("t1_rsp", a_rsp_valid, a_rsp_data, a_rsp_addr, a_rsp_err);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        checkOutput("t1_idle", {31'd0, a_rsp_valid}, 32'd0);
        checkOutput("t1_cnt", {16'd0, a_fetch_cnt}, 32'd4);

        // Backpressure holds the response stable
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        pushReq(32'h8, 32'h0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t3_valid", {31'd0, a_rsp_valid}, 32'd1);
            checkOutput("t3_data", a_rsp_data, sb[0].data);
            checkOutput("t3_addr", a_rsp_addr, sb[0].addr);
            checkOutput("t3_req_ready", {31'd0, a_req_ready}, 32'd0);
            checkOutput("t3_cnt", {16'd0, a_fetch_cnt}, 32'd4);
            cycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkRsp("t3_rsp", a_rsp_valid, a_rsp_data, a_rsp_addr, a_rsp_err);
        cycle();
        checkOutput("t3_cnt_after", {16'd0, a_fetch_cnt}, 32'd5);
        checkOutput("t3_idle", {31'd0, a_rsp_valid}, 32'd0);

        // Misaligned, out-of-range, wrapped-below-base and last valid word
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, err_addrs[i], 1'b1, 1'b0);
            pushReq(err_addrs[i], 32'h0);
            cycle();
            checkRsp("t4_rsp", a_rsp_valid, a_rsp_data, a_rsp_addr, a_rsp_err);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        checkOutput("t4_cnt", {16'd0, a_fetch_cnt}, 32'd9);

        // Load on the accept edge returns the old word; refetch sees the new one
        load_we   = 1'b1;
        load_idx  = 8'd5;
        load_data = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
        pushReq(32'h14, 32'h0);
        model_mem[5] = 32'hDEAD_BEEF;
        cycle();
        load_we = 1'b0;
        checkRsp("t6_old", a_rsp_valid, a_rsp_data, a_rsp_addr, a_rsp_err);
        pushReq(32'h14, 32'h0);
        cycle();
        checkRsp("t6_new", a_rsp_valid, a_rsp_data, a_rsp_addr, a_rsp_err);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        checkOutput("t6_cnt", {16'd0, a_fetch_cnt}, 32'd11);

        // Reset while a response is pending drops it and clears the counter
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t6_resp_pending", {31'd0, a_rsp_valid}, 32'd1);
        rst = 1'b1;
        cycle();
        checkOutput("t6_rst_valid", {31'd0, a_rsp_valid}, 32'd0);
        checkOutput("t6_rst_cnt", {16'd0, a_fetch_cnt}, 32'd0);
        sb.delete();

        doReset();

        // LATENCY=3 timing with a non-zero base address
        applyStimulus(1'b1, 32'h1004, 1'b1, 1'b0);
        pushReq(32'h1004, B_BASE);
        #1 checkOutput("t2_req_ready_n", {31'd0, b_req_ready}, 32'd1);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("t2_req_ready_wait", {31'd0, b_req_ready}, 32'd0);
            checkOutput("t2_valid_wait", {31'd0, b_rsp_valid}, 32'd0);
            cycle();
        end
        checkRsp("t2_rsp", b_rsp_valid, b_rsp_data, b_rsp_addr, b_rsp_err);
        cycle();
        checkOutput("t2_cnt", {16'd0, b_fetch_cnt}, 32'd1);
        checkOutput("t2_idle", {31'd0, b_rsp_valid}, 32'd0);

        applyStimulus(1'b1, B_BASE - 32'd4, 1'b1, 1'b0);
        pushReq(B_BASE - 32'd4, B_BASE);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitRspB(6);
        checkRsp("t4b_rsp", b_rsp_valid, b_rsp_data, b_rsp_addr, b_rsp_err);
        cycle();

        // Accept in RESP: the next fetch rides on the completing handshake
        applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0);
        pushReq(32'h1000, B_BASE);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitRspB(6);
        checkRsp("tb2b_first", b_rsp_valid, b_rsp_data, b_rsp_addr, b_rsp_err);
        applyStimulus(1'b1, 32'h1008, 1'b1, 1'b0);
        pushReq(32'h1008, B_BASE);
        #1 checkOutput("tb2b_req_ready", {31'd0, b_req_ready}, 32'd1);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #1 checkOutput("tb2b_gap", {31'd0, b_rsp_valid}, 32'd0);
        waitRspB(6);
        checkRsp("tb2b_second", b_rsp_valid, b_rsp_data, b_rsp_addr, b_rsp_err);
        cycle();
        checkOutput("tb2b_cnt", {16'd0, b_fetch_cnt}, 32'd4);

        // Flush during WAIT drops the fetch
        applyStimulus(1'b1, 32'h1008, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        #1 checkOutput("t5_req_ready_flush", {31'd0, b_req_ready}, 32'd0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #1 checkOutput("t5_idle_ready", {31'd0, b_req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t5_no_rsp", {31'd0, b_rsp_valid}, 32'd0);
            cycle();
        end
        checkOutput("t5_cnt", {16'd0, b_fetch_cnt}, 32'd4);
        applyStimulus(1'b1, 32'h100C, 1'b1, 1'b0);
        pushReq(32'h100C, B_BASE);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitRspB(6);
        checkRsp("t5_refetch", b_rsp_valid, b_rsp_data, b_rsp_addr, b_rsp_err);
        cycle();
        checkOutput("t5_cnt_after", {16'd0, b_fetch_cnt}, 32'd5);

        // Flush beats a simultaneous rsp_ready
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        waitRspB(6);
        checkOutput("t5r_pending", {31'd0, b_rsp_valid}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5r_dropped", {31'd0, b_rsp_valid}, 32'd0);
        checkOutput("t5r_cnt", {16'd0, b_fetch_cnt}, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
